// File: rtl/mau_arbiter.sv
// Two-port arbiter in front of the single memory access unit: one word access at a time,
// misaligned addresses rejected locally, and a response-timeout guard on the MAU.
module mau_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,
  output logic              mau_access_enable,
  output logic              mau_read_enable,
  output logic              mau_write_enable,
  output logic [ADDR_W-1:0] mau_access_addr,
  output logic [DATA_W-1:0] mau_write_data,
  input  logic [DATA_W-1:0] mau_read_data,
  input  logic              mau_data_valid,
  input  logic              mau_write_done
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_q, en_d, rd_q, rd_d, wr_q, wr_d;
  logic               rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               prio0_c;
  logic               done_c;
  logic               sel_we_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_wdata_c;

  // Port 0 wins a tie under fixed priority, or when port 1 was granted last.
  assign prio0_c    = (FIXED_PRIO != 0) || last_q;
  assign req0_ready = (state_q == S_IDLE) && req0_valid && (!req1_valid || prio0_c);
  assign req1_ready = (state_q == S_IDLE) && req1_valid && (!req0_valid || !prio0_c);

  assign sel_we_c    = req1_ready ? req1_we    : req0_we;
  assign sel_addr_c  = req1_ready ? req1_addr  : req0_addr;
  assign sel_wdata_c = req1_ready ? req1_wdata : req0_wdata;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          owner_d = req1_ready;
          last_d  = req1_ready;
          we_d    = sel_we_c;
          addr_d  = sel_addr_c;
          wdata_d = sel_wdata_c;
          if (sel_addr_c[1:0] != 2'b00) begin
            state_d = S_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
            rv0_d   = !req1_ready;
            rv1_d   = req1_ready;
          end else begin
            state_d = S_ISSUE;
            en_d    = 1'b1;
            rd_d    = !sel_we_c;
            wr_d    = sel_we_c;
          end
        end
      end
      S_ISSUE: begin
        cnt_d  = cnt_q + CNT_W'(1);
        done_c = we_q ? mau_write_done : mau_data_valid;
        // Completion takes precedence over a simultaneous timeout.
        if (done_c || (TO_EN && (cnt_q == CNT_W'(TO_LAST)))) begin
          state_d = S_RESP;
          rdata_d = (done_c && !we_q) ? mau_read_data : '0;
          err_d   = !done_c;
          rv0_d   = !owner_q;
          rv1_d   = owner_q;
        end else begin
          en_d = 1'b1;
          rd_d = !we_q;
          wr_d = we_q;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mau_access_enable = en_q;
  assign mau_read_enable   = rd_q;
  assign mau_write_enable  = wr_q;
  assign mau_access_addr   = addr_q;
  assign mau_write_data    = wdata_q;
  assign resp0_valid       = rv0_q;
  assign resp1_valid       = rv1_q;
  assign resp0_rdata       = rdata_q;
  assign resp1_rdata       = rdata_q;
  assign resp0_err         = err_q;
  assign resp1_err         = err_q;

endmodule

// File: tb/tb_mau_arbiter.sv
// Bench for mau_arbiter: instance 0 is round-robin, instance 1 fixed priority, both with
// an 8-cycle timeout; every access is predicted from the arbitration and timing rules.
module tb_mau_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          TO = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          rq_v  [2][2];
  logic          rq_we [2][2];
  logic [AW-1:0] rq_a  [2][2];
  logic [DW-1:0] rq_wd [2][2];
  logic          rq_rdy[2][2];
  logic          rs_v  [2][2];
  logic          rs_err[2][2];
  logic [DW-1:0] rs_rd [2][2];
  logic          m_en[2], m_re[2], m_we[2], m_dv[2], m_done[2];
  logic [AW-1:0] m_a[2];
  logic [DW-1:0] m_wd[2], m_rd[2];

  int n_cmp = 0;
  int n_bad = 0;
  bit last_m[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mau_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk(clk), .resetn(resetn),
      .req0_valid(rq_v[g][0]), .req0_we(rq_we[g][0]), .req0_addr(rq_a[g][0]),
      .req0_wdata(rq_wd[g][0]), .req0_ready(rq_rdy[g][0]),
      .req1_valid(rq_v[g][1]), .req1_we(rq_we[g][1]), .req1_addr(rq_a[g][1]),
      .req1_wdata(rq_wd[g][1]), .req1_ready(rq_rdy[g][1]),
      .resp0_valid(rs_v[g][0]), .resp0_rdata(rs_rd[g][0]), .resp0_err(rs_err[g][0]),
      .resp1_valid(rs_v[g][1]), .resp1_rdata(rs_rd[g][1]), .resp1_err(rs_err[g][1]),
      .mau_access_enable(m_en[g]), .mau_read_enable(m_re[g]), .mau_write_enable(m_we[g]),
      .mau_access_addr(m_a[g]), .mau_write_data(m_wd[g]), .mau_read_data(m_rd[g]),
      .mau_data_valid(m_dv[g]), .mau_write_done(m_done[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access on instance d, started at a negedge while the instance is idle; lat is
  // the ISSUE cycle on which the MAU completes (0 = never). Returns the granted port.
  task automatic txn(input int d, input bit v0, input bit v1, input bit we0, input bit we1,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                     input int lat, input logic [DW-1:0] rdat, output int w);
    bit we, done;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int ncyc;
    rq_v[d][0] = v0;  rq_v[d][1] = v1;
    rq_we[d][0] = we0; rq_we[d][1] = we1;
    rq_a[d][0] = a0;  rq_a[d][1] = a1;
    rq_wd[d][0] = wd0; rq_wd[d][1] = wd1;
    if (v0 && v1) w = (d == 1) ? 0 : (last_m[d] ? 0 : 1);
    else          w = v1 ? 1 : 0;
    we = (w == 1) ? we1 : we0;
    a  = (w == 1) ? a1 : a0;
    wd = (w == 1) ? wd1 : wd0;
    #1;
    chk("ready_winner", rq_rdy[d][w], 1'b1);
    chk("ready_loser", rq_rdy[d][1-w], 1'b0);
    @(posedge clk); @(negedge clk);
    rq_v[d][w] = 1'b0;
    if (a[1:0] != 2'b00) begin
      done = 1'b0;
      ncyc = 0;
    end else begin
      done = (lat != 0) && (lat <= TO);
      ncyc = done ? lat : TO;
    end
    for (int n = 1; n <= ncyc; n++) begin
      chk("issue_en", m_en[d], 1'b1);
      chk("issue_re", m_re[d], !we);
      chk("issue_we", m_we[d], we);
      chk("issue_addr", m_a[d], a);
      if (we) chk("issue_wdata", m_wd[d], wd);
      chk("issue_no_resp", rs_v[d][0] | rs_v[d][1], 1'b0);
      m_rd[d] = $urandom;
      if (we) begin
        m_done[d] = done && (n == ncyc);
        m_dv[d]   = 1'($urandom_range(0, 1));
      end else begin
        m_dv[d]   = done && (n == ncyc);
        m_done[d] = 1'($urandom_range(0, 1));
        if (done && n == ncyc) m_rd[d] = rdat;
      end
      @(posedge clk); @(negedge clk);
      m_dv[d] = 1'b0;
      m_done[d] = 1'b0;
    end
    chk("resp_valid", rs_v[d][w], 1'b1);
    chk("resp_other", rs_v[d][1-w], 1'b0);
    chk("resp_err", rs_err[d][w], !done);
    chk("resp_rdata", rs_rd[d][w], (done && !we) ? rdat : '0);
    chk("resp_mau_en", m_en[d] | m_re[d] | m_we[d], 1'b0);
    chk("resp_ready", rq_rdy[d][0] | rq_rdy[d][1], 1'b0);
    @(posedge clk); @(negedge clk);
    chk("resp_pulse_end", rs_v[d][w], 1'b0);
    rq_v[d][0] = 1'b0;
    rq_v[d][1] = 1'b0;
    last_m[d] = w[0];
  endtask

  initial begin
    int w, wp;
    logic [31:0] r;
    bit v0, v1;
    logic [1:0] lo;
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      last_m[d] = 1'b1;
      m_rd[d] = '0; m_dv[d] = 1'b0; m_done[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        rq_v[d][p] = 1'b0; rq_we[d][p] = 1'b0; rq_a[d][p] = '0; rq_wd[d][p] = '0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_mau", {m_en[d], m_re[d], m_we[d]}, 3'b000);
      chk("rst_resp", {rs_v[d][0], rs_v[d][1], rs_err[d][0], rs_err[d][1]}, 4'b0000);
      chk("rst_rdata", rs_rd[d][0], '0);
      chk("rst_addr", m_a[d], '0);
    end
    @(negedge clk);
    resetn = 1'b1;

    // Basic read and write on the round-robin instance.
    txn(0, 1, 0, 0, 0, 32'h4, 32'h0, 32'h0, 32'h0, 3, 32'hCAFEBABE, w);
    txn(0, 0, 1, 0, 1, 32'h0, 32'h8, 32'h0, 32'hDEADBEEF, 2, 32'h0, w);

    // Continuous contention: alternate on round-robin, port 0 always on fixed priority.
    wp = 1;
    for (int i = 0; i < 4; i++) begin
      txn(0, 1, 1, 0, 1, 32'h100 + 32'(4*i), 32'h200, 32'h0, 32'h55, 1 + i, 32'h1000 + 32'(i), w);
      chk("rr_alternate", 32'(w), 32'(1 - wp));
      wp = w;
    end
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, 1, 0, 1, 32'h300, 32'h400, 32'h0, 32'hAA, 2, 32'h77, w);
      chk("fixed_prio_port0", 32'(w), 32'd0);
    end

    // Timeout, completion on the last legal cycle, and misalignment.
    txn(0, 1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'h0, 0, 32'h0, w);
    txn(0, 1, 0, 0, 0, 32'h24, 32'h0, 32'h0, 32'h0, 2, 32'h12345678, w);
    txn(0, 0, 1, 0, 0, 32'h0, 32'h28, 32'h0, 32'h0, TO, 32'h9ABCDEF0, w);
    txn(0, 0, 1, 1, 1, 32'h0, 32'h2C, 32'h0, 32'h1111, TO + 1, 32'h0, w);
    txn(0, 0, 1, 0, 0, 32'h0, 32'h6, 32'h0, 32'h0, 1, 32'h0, w);

    // Asynchronous reset while the MAU is enabled.
    rq_v[0][1] = 1'b1; rq_we[0][1] = 1'b0; rq_a[0][1] = 32'h10;
    @(posedge clk); @(negedge clk);
    rq_v[0][1] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pre_reset_en", m_en[0], 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_en", {m_en[0], m_re[0], m_we[0]}, 3'b000);
    chk("async_rst_resp", rs_v[0][0] | rs_v[0][1], 1'b0);
    @(negedge clk);
    chk("rst_hold_resp", rs_v[0][0] | rs_v[0][1], 1'b0);
    resetn = 1'b1;
    last_m[0] = 1'b1;
    last_m[1] = 1'b1;
    txn(0, 1, 1, 0, 0, 32'h40, 32'h44, 32'h0, 32'h0, 1, 32'hBEEF, w);
    chk("post_reset_tie", 32'(w), 32'd0);

    // Randomized accesses against the reference rules.
    for (int i = 0; i < 60; i++) begin
      int d;
      logic [AW-1:0] a0, a1;
      d = int'($urandom_range(0, 1));
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      r = $urandom;
      lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a0 = {r[31:2], lo};
      r = $urandom;
      lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a1 = {r[31:2], lo};
      txn(d, v0, v1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a0, a1,
          $urandom, $urandom, int'($urandom_range(0, 10)), $urandom, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
